// File: rtl/ad79x8_pkg.sv
// ad79x8_pkg
// Shared definitions for the AD7908/AD7918/AD7928 SPI link: control-word
// field positions, frame length, code width and the responder state encoding.
// The ADC master reuses the same field layout for its bus_in word.
package ad79x8_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CODE_W     = 12;
  localparam int NUM_CH     = 8;

  // Control-word fields (bit positions in the 16-bit rx frame)
  localparam int WRITE_BIT  = 15;
  localparam int SEQ_BIT    = 14;
  localparam int ADD_HI     = 12;
  localparam int ADD_LO     = 10;
  localparam int PM_HI      = 9;
  localparam int PM_LO      = 8;
  localparam int SHADOW_BIT = 7;
  localparam int RANGE_BIT  = 5;
  localparam int CODING_BIT = 4;

  // ctrl_word holds rx frame bits 15:4, so field N of the frame sits at N-4
  localparam int CTRL_LSB   = 4;
  localparam logic [CODE_W-1:0] CTRL_RESET = 12'h001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Channel address field of a received control word
  function automatic logic [2:0] ctrl_add(input logic [FRAME_BITS-1:0] w);
    return w[ADD_HI:ADD_LO];
  endfunction

endpackage

// File: rtl/ad79x8_responder_if.sv
// ad79x8_responder_if
// Serial pins of the ADC link.
//   sclk    : serial clock, idles high (master drives)
//   cs      : chip select, active low (master drives)
//   din     : control word, MSB first (master drives)
//   dout    : conversion frame, MSB first (responder drives)
//   dout_oe : pad output enable for dout (responder drives)
interface ad79x8_responder_if;
  logic sclk;
  logic cs;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output sclk, output cs, output din, input dout, input dout_oe);
  modport slave  (input sclk, input cs, input din, output dout, output dout_oe);
endinterface

// File: rtl/ad79x8_sync_edge.sv
// ad79x8_sync_edge
// Brings one asynchronous pin into the clk domain and flags its edges.
//   clk   : system clock
//   reset : synchronous, active-low; all flops return to 1 (pin idle level)
//   d     : asynchronous input pin
//   q     : synchronised level
//   rise  : one-clk pulse on a 0->1 transition of q
//   fall  : one-clk pulse on a 1->0 transition of q
module ad79x8_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   q_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= '1;
      q_p1    <= 1'b1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      // stage boundary: previous synchronised level for edge detect
      q_p1    <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign q    = sync_p0[SYNC_STAGES-1];
  assign rise =  q & ~q_p1;
  assign fall = ~q &  q_p1;

endmodule

// File: rtl/ad79x8_responder.sv
// ad79x8_responder
// SPI responder emulating the ADC side of an AD7908/AD7918/AD7928. All pins
// are oversampled in the clk domain; nothing is clocked by sclk.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low
//   spi         : serial pins (sclk, cs, din in; dout, dout_oe out)
//   sample_data : eight 12-bit samples, channel n at [12n+11:12n]
//   channel     : channel address returned in the current/next frame
//   ctrl_word   : last accepted control word (rx frame bits 15:4)
//   ctrl_valid  : one-clk pulse when ctrl_word/channel update
//   frame_done  : one-clk pulse after the 16th sclk fall of a frame
//   frame_abort : one-clk pulse when cs rises before 16 sclk falls
module ad79x8_responder
  import ad79x8_pkg::*;
#(
  parameter int RESOLUTION  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  ad79x8_responder_if.slave        spi,
  input  logic [NUM_CH*CODE_W-1:0] sample_data,
  output logic [2:0]               channel,
  output logic [CODE_W-1:0]        ctrl_word,
  output logic                     ctrl_valid,
  output logic                     frame_done,
  output logic                     frame_abort
);

  localparam logic [CODE_W-1:0] RES_MASK = CODE_W'(12'hFFF << (CODE_W - RESOLUTION));
  localparam logic [4:0]        CNT_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0]        CNT_FULL = 5'(FRAME_BITS);

  // Keep the top RESOLUTION bits; CODING=0 selects twos complement output
  function automatic logic [CODE_W-1:0] fmt_code(input logic [CODE_W-1:0] raw,
                                                 input logic              coding);
    logic [CODE_W-1:0] c;
    c = raw & RES_MASK;
    if (!coding) c[CODE_W-1] = ~c[CODE_W-1];
    return c;
  endfunction

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic din_q, din_rise, din_fall;

  ad79x8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(spi.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  ad79x8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi.cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  ad79x8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .reset(reset), .d(spi.din), .q(din_q), .rise(din_rise), .fall(din_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_q, sclk_rise, din_rise, din_fall};

  logic [CODE_W-1:0] samples [NUM_CH];
  for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
    assign samples[n] = sample_data[CODE_W*n +: CODE_W];
  end

  state_t                  state, state_nxt;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   rx_sr, tx_sr, tx_load;
  logic                    dout_r, oe_r;
  logic                    load, shift, commit, abort, done;

  assign tx_load = {1'b0, channel,
                    fmt_code(samples[channel], ctrl_word[CODING_BIT-CTRL_LSB])};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    if (cs_fall) begin
      // A cs fall always starts a fresh frame, whatever state we were in
      state_nxt = ST_SHIFT;
      load      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_SHIFT: begin
          // bit_cnt stops at 16: the remainder of the cs window is ignored
          shift = sclk_fall && (bit_cnt < CNT_FULL);
          if (sclk_fall && (bit_cnt == CNT_LAST)) begin
            // 16th fall wins over a simultaneous cs rise
            state_nxt = ST_DONE;
          end else if (cs_rise) begin
            state_nxt = ST_IDLE;
            abort     = (bit_cnt < CNT_FULL);
          end
        end
        ST_DONE: begin
          done      = 1'b1;
          commit    = rx_sr[WRITE_BIT];
          state_nxt = cs_q ? ST_IDLE : ST_SHIFT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      dout_r      <= 1'b0;
      oe_r        <= 1'b0;
      channel     <= '0;
      ctrl_word   <= CTRL_RESET;
      ctrl_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      ctrl_valid  <= commit;
      frame_done  <= done;
      frame_abort <= abort;
      if (load) begin
        bit_cnt <= '0;
        dout_r  <= tx_load[FRAME_BITS-1];
        oe_r    <= 1'b1;
      end else begin
        if (shift) begin
          bit_cnt <= bit_cnt + 5'd1;
          // 0-filled shift makes dout fall to 0 after the 16th edge
          dout_r  <= tx_sr[FRAME_BITS-2];
        end
        if (cs_rise) begin
          dout_r <= 1'b0;
          oe_r   <= 1'b0;
        end
      end
      if (commit) begin
        ctrl_word <= rx_sr[WRITE_BIT:CTRL_LSB];
        channel   <= ctrl_add(rx_sr);
      end
    end
  end

  // Shift registers (data only)
  always_ff @(posedge clk) begin
    if (load)       tx_sr <= tx_load;
    else if (shift) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
    if (shift)      rx_sr <= {rx_sr[FRAME_BITS-2:0], din_q};
  end

  assign spi.dout    = dout_r;
  assign spi.dout_oe = oe_r;

endmodule

// File: tb/tb_ad79x8_responder.sv
// tb_ad79x8_responder
// Directed bench: the initial block acts as the SPI master, driving frames
// into a 12-bit and an 8-bit responder and comparing against hand-computed
// frames, register values and pulse counts.
module tb_ad79x8_responder;
  import ad79x8_pkg::*;

  localparam int HALF = 8;   // sclk half period in clk cycles
  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [95:0] sample_data;

  ad79x8_responder_if spi ();
  ad79x8_responder_if spi8 ();
  assign spi8.sclk = spi.sclk;
  assign spi8.cs   = spi.cs;
  assign spi8.din  = spi.din;

  logic [2:0]  channel, channel8;
  logic [11:0] ctrl_word, ctrl_word8;
  logic        ctrl_valid, frame_done, frame_abort;
  logic        ctrl_valid8, frame_done8, frame_abort8;

  ad79x8_responder #(.RESOLUTION(12), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi(spi), .sample_data(sample_data),
    .channel(channel), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
    .frame_done(frame_done), .frame_abort(frame_abort));

  ad79x8_responder #(.RESOLUTION(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .reset(reset), .spi(spi8), .sample_data(sample_data),
    .channel(channel8), .ctrl_word(ctrl_word8), .ctrl_valid(ctrl_valid8),
    .frame_done(frame_done8), .frame_abort(frame_abort8));

  int n_done = 0, n_valid = 0, n_abort = 0;
  always @(posedge clk) begin
    if (frame_done)  n_done  <= n_done + 1;
    if (ctrl_valid)  n_valid <= n_valid + 1;
    if (frame_abort) n_abort <= n_abort + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    sample_data[12*ch +: 12] = v;
  endtask

  // Lowers cs and issues nfalls sclk falling edges; din carries word_in MSB
  // first, then ones. dout is captured before each fall. cs is left low.
  task automatic frame(input logic [15:0] word_in, input int nfalls,
                       output logic [31:0] rx, output logic [31:0] rx8);
    rx  = '0;
    rx8 = '0;
    spi.cs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nfalls; i++) begin
      spi.din = (i < 16) ? word_in[15-i] : 1'b1;
      wait_clks(HALF);
      rx  = {rx[30:0], spi.dout};
      rx8 = {rx8[30:0], spi8.dout};
      spi.sclk = 1'b0;
      wait_clks(HALF);
      spi.sclk = 1'b1;
    end
    wait_clks(HALF);
  endtask

  task automatic cs_release();
    spi.cs = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic full_frame(input logic [15:0] word_in,
                            output logic [31:0] rx, output logic [31:0] rx8);
    frame(word_in, 16, rx, rx8);
    cs_release();
  endtask

  logic [31:0] rx, rx8;
  int d_done, d_valid, d_abort;

  task automatic snap();
    d_done  = n_done;
    d_valid = n_valid;
    d_abort = n_abort;
  endtask

  initial begin
    reset       = 1'b0;
    spi.sclk    = 1'b1;
    spi.cs      = 1'b1;
    spi.din     = 1'b0;
    sample_data = '0;
    set_ch(0, 12'hABC);
    set_ch(3, 12'h123);
    set_ch(5, 12'h800);
    wait_clks(4);

    check("rst_dout",      spi.dout,    0);
    check("rst_oe",        spi.dout_oe, 0);
    check("rst_channel",   channel,     0);
    check("rst_ctrl",      ctrl_word,   12'h001);
    check("rst_pulses",    {ctrl_valid, frame_done, frame_abort}, 0);
    reset = 1'b1;
    wait_clks(4);

    // Plain read of channel 0
    snap();
    full_frame(16'h0000, rx, rx8);
    check("f1_frame",   rx,  32'h0ABC);
    check("f1_frame8",  rx8, 32'h0AB0);
    check("f1_done",    n_done - d_done,   1);
    check("f1_valid",   n_valid - d_valid, 0);
    check("f1_channel", channel, 0);

    // Write ADD=3, CODING=1
    snap();
    full_frame(16'h8C10, rx, rx8);
    check("f2_frame",   rx, 32'h0ABC);
    check("f2_valid",   n_valid - d_valid, 1);
    check("f2_ctrl",    ctrl_word, 12'h8C1);
    check("f2_channel", channel, 3);

    full_frame(16'h0000, rx, rx8);
    check("f3_frame",  rx,  32'h3123);
    check("f3_frame8", rx8, 32'h3120);

    // Write ADD=5, CODING=0; this frame still returns channel 3 straight binary
    full_frame(16'h9420, rx, rx8);
    check("f4_frame",   rx, 32'h3123);
    check("f4_ctrl",    ctrl_word, 12'h942);
    check("f4_channel", channel, 5);

    full_frame(16'h0000, rx, rx8);
    check("f5_frame",  rx,  32'h5000);
    check("f5_frame8", rx8, 32'h5000);

    set_ch(5, 12'h8FF);
    full_frame(16'h0000, rx, rx8);
    check("f6_frame",  rx,  32'h50FF);
    check("f6_frame8", rx8, 32'h50F0);

    // Abort after 9 falls of a write frame
    snap();
    frame(16'h8C10, 9, rx, rx8);
    check("ab_bits", rx, 32'h0A1);
    check("ab_oe_before", spi.dout_oe, 1);
    spi.cs = 1'b1;
    wait_clks(SYNC + 1);
    check("ab_oe_after", spi.dout_oe, 0);
    wait_clks(HALF);
    check("ab_abort",   n_abort - d_abort, 1);
    check("ab_done",    n_done - d_done,   0);
    check("ab_valid",   n_valid - d_valid, 0);
    check("ab_channel", channel,   5);
    check("ab_ctrl",    ctrl_word, 12'h942);

    // 20 falls in one cs window; extra din bits are ones
    snap();
    frame(16'h8C10, 20, rx, rx8);
    cs_release();
    check("x20_frame",   rx, 32'h50FF0);
    check("x20_done",    n_done - d_done,   1);
    check("x20_valid",   n_valid - d_valid, 1);
    check("x20_abort",   n_abort - d_abort, 0);
    check("x20_ctrl",    ctrl_word, 12'h8C1);
    check("x20_channel", channel,   3);

    // Reset in the middle of a frame
    snap();
    frame(16'h9420, 7, rx, rx8);
    reset = 1'b0;
    wait_clks(2);
    check("mr_dout",    spi.dout,    0);
    check("mr_oe",      spi.dout_oe, 0);
    check("mr_channel", channel,     0);
    check("mr_ctrl",    ctrl_word,   12'h001);
    spi.cs = 1'b1;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(HALF);
    check("mr_done",  n_done - d_done,   0);
    check("mr_abort", n_abort - d_abort, 0);
    check("mr_valid", n_valid - d_valid, 0);

    full_frame(16'h0000, rx, rx8);
    check("mr_frame",  rx,  32'h0ABC);
    check("mr_frame8", rx8, 32'h0AB0);
    check("mr_done2",  n_done - d_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
